// File: rtl/key_irq_pkg.sv
// Shared constants for the key interrupt PIO: bus geometry, register map and edge-mode codes.
package key_irq_pkg;

  localparam int unsigned AVS_AW = 2;
  localparam int unsigned AVS_DW = 32;

  localparam logic [AVS_AW-1:0] ADDR_DATA = 2'd0;
  localparam logic [AVS_AW-1:0] ADDR_MASK = 2'd1;
  localparam logic [AVS_AW-1:0] ADDR_EDGE = 2'd2;
  localparam logic [AVS_AW-1:0] ADDR_MODE = 2'd3;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } edge_mode_e;

  // True when the channel's edge pulses match its configured capture mode.
  function automatic logic edge_hit(input logic [1:0] mode, input logic rise, input logic fall);
    logic hit;
    case (edge_mode_e'(mode))
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/key_irq_pio_if.sv
// Avalon-MM slave bundle for the key interrupt PIO (fixed read latency 1).
interface key_irq_pio_if;
  import key_irq_pkg::*;

  logic [AVS_AW-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [AVS_DW-1:0] avs_writedata;
  logic [AVS_DW-1:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );

endinterface

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, stability counter and debounced level with edge pulses.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 2000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned    CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, w_level_nxt;
  logic             r_level_dly;
  logic             w_pressed;

  // Sync flops reset to the released pin level so reset release never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ ACTIVE_LOW;

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    if (w_pressed == r_level) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_MAX) begin
      w_level_nxt = w_pressed;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt       <= '0;
      r_level     <= 1'b0;
      r_level_dly <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_level     <= w_level_nxt;
      r_level_dly <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_dly;
  assign o_fall  = ~r_level & r_level_dly;

endmodule

// File: rtl/key_irq_pio.sv
// Debounced key inputs with per-channel edge capture, interrupt mask and Avalon-MM register file.
module key_irq_pio
  import key_irq_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned DEB_CYCLES     = 2000000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key,
  key_irq_pio_if.slave        avs,
  output logic                irq
);

  logic [NUM_KEYS-1:0]   w_level, w_rise, w_fall, w_set, w_clr;
  logic [NUM_KEYS-1:0]   r_mask, r_edge, w_edge_nxt;
  logic [2*NUM_KEYS-1:0] r_mode;
  logic [AVS_DW-1:0]     r_rdata, w_rd_word;
  logic                  w_wr_mask, w_wr_edge, w_wr_mode;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_deb (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .i_key     (key[gi]),
      .o_level   (w_level[gi]),
      .o_rise    (w_rise[gi]),
      .o_fall    (w_fall[gi])
    );
  end

  if (2 * NUM_KEYS < AVS_DW) begin : g_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^avs.avs_writedata[AVS_DW-1:2*NUM_KEYS];
  end

  assign w_wr_mask = avs.avs_write && (avs.avs_address == ADDR_MASK);
  assign w_wr_edge = avs.avs_write && (avs.avs_address == ADDR_EDGE);
  assign w_wr_mode = avs.avs_write && (avs.avs_address == ADDR_MODE);

  // A new edge wins over a write-1-to-clear landing in the same cycle.
  always_comb begin
    w_set = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_set[i] = edge_hit(r_mode[2*i +: 2], w_rise[i], w_fall[i]);
    end
    w_clr      = w_wr_edge ? avs.avs_writedata[NUM_KEYS-1:0] : '0;
    w_edge_nxt = (r_edge & ~w_clr) | w_set;
  end

  always_comb begin
    w_rd_word = '0;
    case (avs.avs_address)
      ADDR_DATA: w_rd_word[NUM_KEYS-1:0]   = w_level;
      ADDR_MASK: w_rd_word[NUM_KEYS-1:0]   = r_mask;
      ADDR_EDGE: w_rd_word[NUM_KEYS-1:0]   = r_edge;
      ADDR_MODE: w_rd_word[2*NUM_KEYS-1:0] = r_mode;
      default:   w_rd_word                 = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mask  <= '0;
      r_edge  <= '0;
      r_mode  <= '0;
      r_rdata <= '0;
    end else begin
      r_edge <= w_edge_nxt;
      if (w_wr_mask) r_mask <= avs.avs_writedata[NUM_KEYS-1:0];
      if (w_wr_mode) r_mode <= avs.avs_writedata[2*NUM_KEYS-1:0];
      if (avs.avs_read) r_rdata <= w_rd_word;
    end
  end

  assign avs.avs_readdata = r_rdata;
  assign irq              = |(r_edge & r_mask);

endmodule

// File: tb/tb_key_irq_pio.sv
// Directed bench for key_irq_pio with a per-cycle reference model of the register file and irq.
module tb_key_irq_pio;

  localparam int unsigned NK  = 4;
  localparam int unsigned DEB = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key   = '1;
  logic          irq;

  key_irq_pio_if avs_if ();

  key_irq_pio #(
    .NUM_KEYS       (NK),
    .DEB_CYCLES     (DEB),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .key       (key),
    .avs       (avs_if),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pressed-pin history, the debounced level flips once the synchronised
  // pressed value has disagreed with it for DEB consecutive clocks.
  logic [NK-1:0]   hist [0:DEB+1];
  logic [NK-1:0]   m_level, m_prev, m_edge, m_mask;
  logic [2*NK-1:0] m_mode;
  logic [31:0]     m_rdata;

  logic            p_rst_n = 1'b0;
  logic [NK-1:0]   p_key   = '1;
  logic            p_rd    = 1'b0;
  logic            p_wr    = 1'b0;
  logic [1:0]      p_addr  = '0;
  logic [31:0]     p_wdata = '0;

  task automatic model_reset();
    for (int j = 0; j <= int'(DEB) + 1; j++) hist[j] = '0;
    m_level = '0;
    m_prev  = '0;
    m_edge  = '0;
    m_mask  = '0;
    m_mode  = '0;
    m_rdata = '0;
  endtask

  task automatic model_step();
    logic [NK-1:0] set, clr, nlev;
    logic [1:0]    md;
    logic          rise, fall, flip;
    if (p_rd) begin
      case (p_addr)
        2'd0:    m_rdata = 32'(m_level);
        2'd1:    m_rdata = 32'(m_mask);
        2'd2:    m_rdata = 32'(m_edge);
        default: m_rdata = 32'(m_mode);
      endcase
    end
    for (int i = 0; i < int'(NK); i++) begin
      rise   = m_level[i] && !m_prev[i];
      fall   = !m_level[i] && m_prev[i];
      md     = m_mode[2*i +: 2];
      set[i] = (md == 2'd0 && rise) || (md == 2'd1 && fall) || (md == 2'd2 && (rise || fall));
    end
    clr = (p_wr && p_addr == 2'd2) ? p_wdata[NK-1:0] : '0;
    if (p_wr && p_addr == 2'd1) m_mask = p_wdata[NK-1:0];
    if (p_wr && p_addr == 2'd3) m_mode = p_wdata[2*NK-1:0];
    for (int j = int'(DEB) + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = ~p_key;
    nlev = m_level;
    for (int i = 0; i < int'(NK); i++) begin
      flip = 1'b1;
      for (int j = 0; j < int'(DEB); j++) if (hist[2+j][i] == m_level[i]) flip = 1'b0;
      if (flip) nlev[i] = ~m_level[i];
    end
    m_edge  = (m_edge & ~clr) | set;
    m_prev  = m_level;
    m_level = nlev;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n || !p_rst_n) model_reset();
      else model_step();
      check("irq_model", 32'(irq), 32'(|(m_edge & m_mask)));
      check("readdata_model", avs_if.avs_readdata, m_rdata);
      p_rst_n = rst_n;
      p_key   = key;
      p_rd    = avs_if.avs_read;
      p_wr    = avs_if.avs_write;
      p_addr  = avs_if.avs_address;
      p_wdata = avs_if.avs_writedata;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_key(input logic [NK-1:0] v);
    @(posedge clk); #1 key = v;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avs_if.avs_address   = a;
    avs_if.avs_writedata = d;
    avs_if.avs_write     = 1'b1;
    @(posedge clk); #1 avs_if.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    avs_if.avs_address = a;
    avs_if.avs_read    = 1'b1;
    @(posedge clk); #1 avs_if.avs_read = 1'b0;
    check(name, avs_if.avs_readdata, exp);
  endtask

  initial begin
    avs_if.avs_address   = '0;
    avs_if.avs_read      = 1'b0;
    avs_if.avs_write     = 1'b0;
    avs_if.avs_writedata = '0;

    // Reset state and no capture on release with keys idle
    idle(3);
    #1 rst_n = 1'b1;
    bus_read(2'd0, 32'h0, "rst_data");
    bus_read(2'd1, 32'h0, "rst_mask");
    bus_read(2'd2, 32'h0, "rst_edge");
    bus_read(2'd3, 32'h0, "rst_mode");
    check("rst_irq", 32'(irq), 32'h0);
    idle(20);
    bus_read(2'd2, 32'h0, "rst_no_capture");

    // Glitch shorter than the debounce window, then a real press
    set_key(4'hE);
    idle(5);
    set_key(4'hF);
    idle(15);
    bus_read(2'd0, 32'h0, "glitch_data");
    bus_read(2'd2, 32'h0, "glitch_edge");
    set_key(4'hE);
    idle(12);
    bus_read(2'd0, 32'h1, "press_data");
    bus_read(2'd2, 32'h1, "press_edge");

    // irq latency, write-0 no-op, write-1 clear
    bus_write(2'd2, 32'h1);
    bus_write(2'd1, 32'h1);
    set_key(4'hF);
    idle(15);
    bus_read(2'd2, 32'h0, "release_rise_mode");
    set_key(4'hE);
    idle(10);
    #1 check("irq_before_capture", 32'(irq), 32'h0);
    @(posedge clk); #1 check("irq_after_capture", 32'(irq), 32'h1);
    bus_write(2'd2, 32'h0);
    check("irq_w0_noop", 32'(irq), 32'h1);
    bus_read(2'd2, 32'h1, "edge_w0_noop");
    bus_write(2'd2, 32'h1);
    check("irq_w1c", 32'(irq), 32'h0);

    // Edge modes: ch1 fall, ch2 both, ch3 off
    set_key(4'hF);
    idle(15);
    bus_write(2'd3, 32'hE4);
    bus_read(2'd3, 32'hE4, "mode_rb");
    set_key(4'h1);
    idle(15);
    bus_read(2'd0, 32'hE, "mode_press_data");
    bus_read(2'd2, 32'h4, "mode_press_edge");
    set_key(4'hF);
    idle(15);
    bus_read(2'd2, 32'h6, "mode_release_edge");
    bus_write(2'd2, 32'hF);
    bus_read(2'd2, 32'h0, "mode_clear");

    // Clear write on the same cycle as a ch2 capture: set wins
    set_key(4'hB);
    idle(9);
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, 32'h4, "set_beats_clear");
    bus_write(2'd1, 32'h4);
    check("irq_mask_on", 32'(irq), 32'h1);
    bus_write(2'd1, 32'h1);
    check("irq_mask_off", 32'(irq), 32'h0);

    // Reset mid-debounce with irq pending
    bus_write(2'd1, 32'h5);
    set_key(4'hA);
    idle(4);
    check("irq_pre_reset", 32'(irq), 32'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check("irq_async_reset", 32'(irq), 32'h0);
    idle(3);
    #1 rst_n = 1'b1;
    bus_read(2'd0, 32'h0, "post_rst_data");
    bus_read(2'd1, 32'h0, "post_rst_mask");
    bus_read(2'd2, 32'h0, "post_rst_edge");
    bus_read(2'd3, 32'h0, "post_rst_mode");
    idle(15);
    bus_read(2'd0, 32'h5, "resume_data");
    bus_read(2'd2, 32'h5, "resume_edge");
    bus_write(2'd1, 32'h4);
    check("resume_irq", 32'(irq), 32'h1);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
